wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Registered MEM/WB writeback stage. Parametrised successor to the combinational writeback select.
//  Accepts one instruction per cycle from MEM via a valid/ready handshake.
//  Aligns and sign/zero-extends load data (byte, half, word, double) using the address offset.
//  Selects the writeback source and drives the register-file write port one cycle after acceptance.
//  Stalls on loads whose data has not yet returned.
// PARAMETERS
//  XLEN     64  datapath width; legal values are 32 and 64
//  PC_W     32  program-counter width
//  OFF_W    $clog2(XLEN/8)  byte-offset width (derived; do not override)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      MEM presents an instruction
//  in_ready   out  1      stage can accept this cycle
//  flush      in   1      kill the in-flight instruction and the input beat
//  wb_sel     in   2      00 ALU, 01 MEM, 10 PC+4, 11 CSR
//  funct3     in   3      load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
//  reg_write  in   1      instruction writes rd
//  rd         in   5      destination register
//  alu_result in   XLEN   ALU result
//  csr_rdata  in   XLEN   CSR read data
//  pc         in   PC_W   instruction PC
//  addr_lo    in   OFF_W  load byte offset within the XLEN word
//  mem_rvalid in   1      load data valid (same cycle as accept, or later)
//  mem_rdata  in   XLEN   raw, unaligned load word
//  rf_we      out  1      register-file write enable (registered)
//  rf_waddr   out  5      register-file write address (registered)
//  rf_wdata   out  XLEN   register-file write data (registered)
//  retire     out  1      one-cycle pulse per completed instruction
//  load_err   out  1      one-cycle pulse: misaligned access or illegal funct3; no write occurs
// BEHAVIOUR
//  Reset (async): all outputs are 0 and state is IDLE. in_ready is 1 after reset release.
//  Accept: in_valid & in_ready & !flush.
//  States:
//   - IDLE/RUN: in_ready = 1.
//     - Accept of a non-load, or a load with mem_rvalid=1 -> outputs update at the next edge (latency 1).
//     - Accept of a load with mem_rvalid=0 -> WAIT. Fields are captured.
//   - WAIT: in_ready = 0.
//     - mem_rvalid=1 -> outputs update at the next edge, then RUN.
//     - flush -> IDLE. No write and no retire.
//  Outputs: rf_we, retire and load_err are one-cycle pulses; they deassert unless a new result completes.
//  rf_waddr and rf_wdata hold their last value.
//  rf_we = reg_write & (rd != 0) & !load_err.
//  Writeback data:
//   - ALU -> alu_result.
//   - CSR -> csr_rdata.
//   - PC+4 -> zero-extend(pc + 4) to XLEN. PC wraps modulo 2^PC_W.
//   - MEM -> (mem_rdata >> 8*addr_lo), then extend per funct3 from bit 7/15/31.
//  Misaligned loads assert load_err and do not write:
//   - lh/lhu with addr_lo[0] != 0.
//   - lw/lwu with addr_lo[1:0] != 0.
//   - ld with addr_lo != 0.
//  Illegal funct3 asserts load_err and does not write: 111 always; 011 and 110 when XLEN=32.
//  load_err still asserts retire (the trap is taken downstream).
//  flush with accept in the same cycle: the input is dropped; a result already completing this cycle is unaffected.
//  mem_rvalid outside WAIT and outside a load accept is ignored.
//  wb_sel=01 with reg_write=0 is treated as a load and still waits for data.
// CONFIGURATION
//  `WB_INSTRET_EN defined:
//   - adds output instret [63:0].
//   - reset value 0; +1 on every retire pulse; wraps at 2^64.
//  Not defined: no port and no counter logic.
// STRUCTURE
//  wb_pkg holds:
//   - the wb_sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_CSR).
//   - the funct3 load constants.
//   - the state enum (IDLE, WAIT).
//  Sub-module wb_load_ext (combinational): mem_rdata, addr_lo, funct3 -> ext_data, misaligned, illegal.
//  Instantiated once.
// TESTING
//  1. ALU write: wb_sel=00, rd=5, alu=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, retire=1.
//  2. lb: rdata=0x..80_00, addr_lo=1 -> wdata=0xFFFF_FFFF_FFFF_FF80.
//     lbu, same inputs -> wdata=0x80.
//  3. Load stall: load accepted with mem_rvalid=0 -> in_ready=0 for 3 cycles.
//     rvalid on cycle 3 -> write on cycle 4, then in_ready=1.
//  4. Flush in WAIT -> state IDLE, no rf_we, no retire; next instruction accepted the following cycle.
//  5. lh at addr_lo=3 -> load_err=1, retire=1, rf_we=0.
//     rd=0 ALU op -> rf_we=0, retire=1.
//  6. jal: pc=0xFFFF_FFFC, wb_sel=10 -> wdata=0; with `WB_INSTRET_EN, instret counts each retire pulse.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: writeback source
// encodings, load funct3 codes and the stage state enum.
package wb_pkg;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    // Load type (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // IDLE doubles as the RUN state: both accept one instruction per cycle
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

    // An instruction is handled as a load whenever it writes back from MEM,
    // regardless of reg_write
    function automatic logic is_load(input logic [1:0] sel);
        return sel == WB_MEM;
    endfunction

endpackage

// File: rtl/wb_if.sv
// MEM -> WB instruction bundle.
// Handshake: a beat transfers on a rising clk edge where in_valid & in_ready
// are both high and flush is low. MEM holds its fields stable while in_valid
// is high and in_ready is low; in_ready does not depend on in_valid.
// mem_rvalid/mem_rdata deliver load data in the accept cycle or any later one.
interface wb_if #(
    parameter int XLEN  = 64,
    parameter int PC_W  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [1:0]       wb_sel;
    logic [2:0]       funct3;
    logic             reg_write;
    logic [4:0]       rd;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  csr_rdata;
    logic [PC_W-1:0]  pc;
    logic [OFF_W-1:0] addr_lo;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;

    modport master (
        output in_valid, flush, wb_sel, funct3, reg_write, rd,
               alu_result, csr_rdata, pc, addr_lo, mem_rvalid, mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, flush, wb_sel, funct3, reg_write, rd,
               alu_result, csr_rdata, pc, addr_lo, mem_rvalid, mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/wb_load_ext.sv
// Load data aligner: shifts the raw word down by the byte offset, then sign-
// or zero-extends per funct3. Flags misaligned offsets and illegal funct3.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int  XLEN  = 64,
    localparam int OFF_W = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [OFF_W-1:0] addr_lo,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  ext_data,
    output logic             misaligned,
    output logic             illegal
);

    // Keep the low 'bits' bits of v, optionally replicating bit bits-1 above
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int bits,
                                               input logic sgn);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] res;
        mask = (bits >= XLEN) ? '1 : ((XLEN'(1) << bits) - XLEN'(1));
        res  = v & mask;
        if (sgn && v[bits-1]) begin
            res = res | ~mask;
        end
        return res;
    endfunction

    logic [XLEN-1:0] shifted;

    // Align and extend; doubleword and lwu only exist on a 64-bit datapath
    always_comb begin
        shifted    = mem_rdata >> {addr_lo, 3'b000};
        ext_data   = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_LB:  ext_data = extend(shifted, 8, 1'b1);
            F3_LBU: ext_data = extend(shifted, 8, 1'b0);
            F3_LH: begin
                ext_data   = extend(shifted, 16, 1'b1);
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                ext_data   = extend(shifted, 16, 1'b0);
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                ext_data   = extend(shifted, 32, 1'b1);
                misaligned = (addr_lo[1:0] != 2'b00);
            end
            F3_LWU: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else begin
                    ext_data   = extend(shifted, 32, 1'b0);
                    misaligned = (addr_lo[1:0] != 2'b00);
                end
            end
            F3_LD: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else begin
                    ext_data   = shifted;
                    misaligned = (addr_lo != '0);
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB writeback stage. Accepts one instruction per cycle,
// parks in WAIT while a load's data is outstanding, and drives the register
// file write port one cycle after the result is complete.
// Optional feature: define WB_INSTRET_EN to add a 64-bit retired-instruction
// counter output (instret).
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_if.slave             mem_if,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            retire,
    output logic            load_err,
`ifdef WB_INSTRET_EN
    output logic [63:0]     instret,
`endif
    output wb_state_e       state_dbg
);

    localparam int OFF_W = $clog2(XLEN/8);

    wb_state_e        state_q, state_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [OFF_W-1:0] addr_lo_q, addr_lo_d;

    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic             retire_q, retire_d;
    logic             load_err_q, load_err_d;

    logic             in_ready;
    logic             accept;
    logic             in_is_load;
    logic [2:0]       ld_funct3;
    logic [OFF_W-1:0] ld_addr_lo;
    logic [XLEN-1:0]  ext_data;
    logic             misaligned;
    logic             illegal;
    logic [PC_W-1:0]  pc_plus4;

    logic             complete;
    logic             c_reg_write;
    logic [4:0]       c_rd;
    logic             c_is_load;
    logic [XLEN-1:0]  c_data;
    logic             c_err;

    assign in_ready        = (state_q == IDLE);
    assign mem_if.in_ready = in_ready;
    assign accept          = mem_if.in_valid & in_ready & ~mem_if.flush;
    assign in_is_load      = is_load(mem_if.wb_sel);
    assign pc_plus4        = mem_if.pc + PC_W'(4);

    // While waiting, the aligner works from the captured load fields
    always_comb begin
        ld_funct3  = (state_q == WAIT) ? funct3_q  : mem_if.funct3;
        ld_addr_lo = (state_q == WAIT) ? addr_lo_q : mem_if.addr_lo;
    end

    wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .mem_rdata  (mem_if.mem_rdata),
        .addr_lo    (ld_addr_lo),
        .funct3     (ld_funct3),
        .ext_data   (ext_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    // Next state, field capture and result formation
    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        complete    = 1'b0;
        c_reg_write = 1'b0;
        c_rd        = '0;
        c_is_load   = 1'b0;
        c_data      = '0;
        c_err       = 1'b0;
        rf_we_d     = 1'b0;
        retire_d    = 1'b0;
        load_err_d  = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_load || mem_if.mem_rvalid) begin
                        complete    = 1'b1;
                        c_reg_write = mem_if.reg_write;
                        c_rd        = mem_if.rd;
                        c_is_load   = in_is_load;
                        case (mem_if.wb_sel)
                            WB_ALU:  c_data = mem_if.alu_result;
                            WB_MEM:  c_data = ext_data;
                            WB_PC4:  c_data = XLEN'(pc_plus4);
                            default: c_data = mem_if.csr_rdata;
                        endcase
                    end else begin
                        state_d     = WAIT;
                        reg_write_d = mem_if.reg_write;
                        rd_d        = mem_if.rd;
                        funct3_d    = mem_if.funct3;
                        addr_lo_d   = mem_if.addr_lo;
                    end
                end
            end
            WAIT: begin
                // A kill wins over data arriving in the same cycle
                if (mem_if.flush) begin
                    state_d = IDLE;
                end else if (mem_if.mem_rvalid) begin
                    state_d     = IDLE;
                    complete    = 1'b1;
                    c_reg_write = reg_write_q;
                    c_rd        = rd_q;
                    c_is_load   = 1'b1;
                    c_data      = ext_data;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            c_err      = c_is_load & (misaligned | illegal);
            retire_d   = 1'b1;
            load_err_d = c_err;
            rf_we_d    = c_reg_write & (c_rd != 5'd0) & ~c_err;
            if (!c_err) begin
                rf_waddr_d = c_rd;
                rf_wdata_d = c_data;
            end
        end
    end

    // State, captured load fields and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            retire_q    <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            retire_q    <= retire_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign retire    = retire_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Counter advances on the same edge that launches each retire pulse
    always_comb begin
        instret_d = instret_q + 64'(retire_d);
    end

    // Retired-instruction counter register, wraps naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (XLEN=64, PC_W=32). Each scenario task drives
// stimulus and compares the registered outputs 1ns after the rising edge.
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        retire;
    logic        load_err;
    wb_state_e   state_dbg;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_total;
    int n_pass;
    int exp_retires;

    wb_if #(.XLEN(64), .PC_W(32)) mif ();

    wb_stage #(.XLEN(64), .PC_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_if    (mif.slave),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .retire    (retire),
        .load_err  (load_err),
`ifdef WB_INSTRET_EN
        .instret   (instret),
`endif
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: set every input at the falling edge, sample 1ns after the rise
    task automatic drive_cycle(input logic [1:0] sel, input logic [2:0] f3,
                               input logic rw, input logic [4:0] rd,
                               input logic [63:0] alu, input logic [63:0] csr,
                               input logic [31:0] pc, input logic [2:0] addr,
                               input logic rv, input logic [63:0] rdata,
                               input logic valid, input logic fl);
        @(negedge clk);
        mif.in_valid   = valid;
        mif.flush      = fl;
        mif.wb_sel     = sel;
        mif.funct3     = f3;
        mif.reg_write  = rw;
        mif.rd         = rd;
        mif.alu_result = alu;
        mif.csr_rdata  = csr;
        mif.pc         = pc;
        mif.addr_lo    = addr;
        mif.mem_rvalid = rv;
        mif.mem_rdata  = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(WB_ALU, 3'd0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mif.in_valid = 0; mif.flush = 0; mif.wb_sel = 0; mif.funct3 = 0;
        mif.reg_write = 0; mif.rd = 0; mif.alu_result = 0; mif.csr_rdata = 0;
        mif.pc = 0; mif.addr_lo = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({rf_we, retire, load_err, rf_waddr} !== 8'd0 || rf_wdata !== 64'd0) begin
            $display("FAIL reset_outputs: got we=%0b ret=%0b err=%0b waddr=%0d wdata=%h, want all 0",
                     rf_we, retire, load_err, rf_waddr, rf_wdata);
        end else n_pass++;
        n_total++;
        if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d want IDLE", state_dbg);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++;
        if (mif.in_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", mif.in_ready);
        else n_pass++;
    endtask

    task automatic test_alu_csr();
        drive_cycle(WB_ALU, 3'd0, 1'b1, 5'd5, 64'h1234, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b110) $display("FAIL alu_flags: got %b want 110", {rf_we, retire, load_err});
        else n_pass++;
        n_total++;
        if (rf_waddr !== 5'd5 || rf_wdata !== 64'h1234)
            $display("FAIL alu_write: got waddr=%0d wdata=%h want 5/1234", rf_waddr, rf_wdata);
        else n_pass++;
        idle_cycle();
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b000 || rf_wdata !== 64'h1234)
            $display("FAIL alu_pulse_end: got flags=%b wdata=%h want 000/1234", {rf_we, retire, load_err}, rf_wdata);
        else n_pass++;
        drive_cycle(WB_CSR, 3'd0, 1'b1, 5'd3, 64'h5, 64'hDEAD_BEEF_0000_0001, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL csr_write: got we=%0b waddr=%0d wdata=%h want 1/3/deadbeef00000001", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t [6];
        logic [2:0]  addr_t [6];
        logic [63:0] rd_t [6];
        logic [63:0] exp_t [6];
        f3_t[0] = F3_LB;  addr_t[0] = 3'd1; rd_t[0] = 64'h0000_0000_0000_8000; exp_t[0] = 64'hFFFF_FFFF_FFFF_FF80;
        f3_t[1] = F3_LBU; addr_t[1] = 3'd1; rd_t[1] = 64'h0000_0000_0000_8000; exp_t[1] = 64'h0000_0000_0000_0080;
        f3_t[2] = F3_LH;  addr_t[2] = 3'd2; rd_t[2] = 64'h0000_0000_8001_0000; exp_t[2] = 64'hFFFF_FFFF_FFFF_8001;
        f3_t[3] = F3_LW;  addr_t[3] = 3'd4; rd_t[3] = 64'h8765_4321_0000_0000; exp_t[3] = 64'hFFFF_FFFF_8765_4321;
        f3_t[4] = F3_LWU; addr_t[4] = 3'd4; rd_t[4] = 64'h8765_4321_0000_0000; exp_t[4] = 64'h0000_0000_8765_4321;
        f3_t[5] = F3_LD;  addr_t[5] = 3'd0; rd_t[5] = 64'h0123_4567_89AB_CDEF; exp_t[5] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(WB_MEM, f3_t[i], 1'b1, 5'd10, 64'd0, 64'd0, 32'd0, addr_t[i], 1'b1, rd_t[i], 1'b1, 1'b0);
            exp_retires++;
            n_total++;
            if ({rf_we, retire, load_err} !== 3'b110)
                $display("FAIL load_flags[%0d]: got %b want 110", i, {rf_we, retire, load_err});
            else n_pass++;
            n_total++;
            if (rf_wdata !== exp_t[i] || rf_waddr !== 5'd10)
                $display("FAIL load_data[%0d]: got waddr=%0d wdata=%h want 10/%h", i, rf_waddr, rf_wdata, exp_t[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        // cycle 1 after accept: waiting
        drive_cycle(WB_MEM, F3_LW, 1'b1, 5'd7, 64'd0, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        n_total++;
        if (mif.in_ready !== 1'b0 || state_dbg !== WAIT || rf_we !== 1'b0 || retire !== 1'b0)
            $display("FAIL stall_c1: got ready=%0b state=%0d we=%0b ret=%0b want 0/WAIT/0/0",
                     mif.in_ready, state_dbg, rf_we, retire);
        else n_pass++;
        // live offset changes; the captured offset 0 must be used
        for (int c = 2; c <= 3; c++) begin
            drive_cycle(WB_ALU, 3'd0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 3'd3, 1'b0, 64'd0, 1'b0, 1'b0);
            n_total++;
            if (mif.in_ready !== 1'b0 || retire !== 1'b0)
                $display("FAIL stall_c%0d: got ready=%0b ret=%0b want 0/0", c, mif.in_ready, retire);
            else n_pass++;
        end
        drive_cycle(WB_ALU, 3'd0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 3'd3, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b110 || rf_waddr !== 5'd7 || rf_wdata !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL stall_write: got flags=%b waddr=%0d wdata=%h want 110/7/fffffffffffffffe",
                     {rf_we, retire, load_err}, rf_waddr, rf_wdata);
        else n_pass++;
        n_total++;
        if (mif.in_ready !== 1'b1 || state_dbg !== IDLE)
            $display("FAIL stall_release: got ready=%0b state=%0d want 1/IDLE", mif.in_ready, state_dbg);
        else n_pass++;
    endtask

    task automatic test_flush();
        drive_cycle(WB_MEM, F3_LD, 1'b1, 5'd11, 64'd0, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        drive_cycle(WB_ALU, 3'd0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b0, 1'b1);
        n_total++;
        if (state_dbg !== IDLE || {rf_we, retire, load_err} !== 3'b000)
            $display("FAIL flush_wait: got state=%0d flags=%b want IDLE/000", state_dbg, {rf_we, retire, load_err});
        else n_pass++;
        drive_cycle(WB_ALU, 3'd0, 1'b1, 5'd9, 64'h99, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire} !== 2'b11 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99)
            $display("FAIL flush_next: got we=%0b ret=%0b waddr=%0d wdata=%h want 1/1/9/99", rf_we, retire, rf_waddr, rf_wdata);
        else n_pass++;
        drive_cycle(WB_ALU, 3'd0, 1'b1, 5'd12, 64'h77, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b000 || rf_waddr !== 5'd9)
            $display("FAIL flush_accept: got flags=%b waddr=%0d want 000/9", {rf_we, retire, load_err}, rf_waddr);
        else n_pass++;
    endtask

    task automatic test_errors();
        drive_cycle(WB_MEM, F3_LH, 1'b1, 5'd8, 64'd0, 64'd0, 32'd0, 3'd3, 1'b1, 64'hFFFF, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b011) $display("FAIL err_lh_mis: got %b want 011", {rf_we, retire, load_err});
        else n_pass++;
        drive_cycle(WB_MEM, F3_LW, 1'b1, 5'd8, 64'd0, 64'd0, 32'd0, 3'd2, 1'b1, 64'hFFFF, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b011) $display("FAIL err_lw_mis: got %b want 011", {rf_we, retire, load_err});
        else n_pass++;
        drive_cycle(WB_MEM, F3_LD, 1'b1, 5'd8, 64'd0, 64'd0, 32'd0, 3'd4, 1'b1, 64'hFFFF, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b011) $display("FAIL err_ld_mis: got %b want 011", {rf_we, retire, load_err});
        else n_pass++;
        drive_cycle(WB_MEM, 3'b111, 1'b1, 5'd8, 64'd0, 64'd0, 32'd0, 3'd0, 1'b1, 64'hFFFF, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b011) $display("FAIL err_f3_111: got %b want 011", {rf_we, retire, load_err});
        else n_pass++;
        drive_cycle(WB_ALU, 3'd0, 1'b1, 5'd0, 64'h55, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b010) $display("FAIL rd0_alu: got %b want 010", {rf_we, retire, load_err});
        else n_pass++;
        // MEM select without reg_write still waits for data, then retires without writing
        drive_cycle(WB_MEM, F3_LBU, 1'b0, 5'd4, 64'd0, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        n_total++;
        if (state_dbg !== WAIT) $display("FAIL norw_wait: got state=%0d want WAIT", state_dbg);
        else n_pass++;
        drive_cycle(WB_ALU, 3'd0, 1'b0, 5'd0, 64'd0, 64'd0, 32'd0, 3'd0, 1'b1, 64'h12, 1'b0, 1'b0);
        exp_retires++;
        n_total++;
        if ({rf_we, retire, load_err} !== 3'b010) $display("FAIL norw_done: got %b want 010", {rf_we, retire, load_err});
        else n_pass++;
    endtask

    task automatic test_pc4();
        drive_cycle(WB_PC4, 3'd0, 1'b1, 5'd1, 64'h5, 64'd0, 32'hFFFF_FFFC, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 64'd0)
            $display("FAIL pc4_wrap: got we=%0b waddr=%0d wdata=%h want 1/1/0", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        drive_cycle(WB_PC4, 3'd0, 1'b1, 5'd1, 64'h5, 64'd0, 32'h0000_1000, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
        exp_retires++;
        n_total++;
        if (rf_wdata !== 64'h1004) $display("FAIL pc4_plain: got %h want 1004", rf_wdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 64'(i) * 64'h111 + 64'd1;
            drive_cycle(WB_ALU, 3'd0, 1'b1, 5'(i + 20), v, 64'd0, 32'd0, 3'd0, 1'b0, 64'd0, 1'b1, 1'b0);
            exp_retires++;
            n_total++;
            if ({rf_we, retire} !== 2'b11 || rf_waddr !== 5'(i + 20) || rf_wdata !== v)
                $display("FAIL b2b[%0d]: got we=%0b ret=%0b waddr=%0d wdata=%h want 1/1/%0d/%h",
                         i, rf_we, retire, rf_waddr, rf_wdata, i + 20, v);
            else n_pass++;
        end
        idle_cycle();
    endtask

    initial begin
        n_total = 0;
        n_pass = 0;
        exp_retires = 0;
        test_reset();
        test_alu_csr();
        test_load_ext();
        test_stall();
        test_flush();
        test_errors();
        test_pc4();
        test_back_to_back();
`ifdef WB_INSTRET_EN
        n_total++;
        if (instret !== 64'(exp_retires)) $display("FAIL instret: got %0d want %0d", instret, exp_retires);
        else n_pass++;
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
